// File: rtl/mc_datapath_hs_if.sv
// Shared instruction/data memory port of the multicycle core (req/ack handshake).
// Latency: none, wires only; the core holds a request until the memory acks it.
// Backpressure: memory stalls the core by withholding mem_ack; request fields stay stable.
interface mc_datapath_hs_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 16
);
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic [DATA_SIZE-1:0] mem_rdata;
  logic                 mem_ack;

  // core side
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  // memory / arbiter side
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mc_datapath_hs.sv
// Multicycle core: datapath, register file and sequencing FSM on one shared memory port.
// Latency (zero-wait): ALU/LD 4, ST/BEQZ 3, J/NOP/HALT 2 cycles; +1 per cycle without ack.
// Backpressure: FETCH and MEM hold mem_req and its fields until mem_ack; nothing else stalls.
module mc_datapath_hs #(
  parameter int DATA_SIZE = 32,  // 32 or 64
  parameter int ADDR_SIZE = 16,  // up to 32
  parameter int NUM_REGS  = 32,  // 2..32
  parameter int ZERO_R0   = 1,
  parameter int CNT_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 reset,   // asynchronous, active low
  mc_datapath_hs_if.master     mem,
  output logic [ADDR_SIZE-1:0] pc,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_SIZE-1:0]  retired
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5;
  localparam logic [5:0] OP_ORI  = 6'd6;
  localparam logic [5:0] OP_LD   = 6'd7;
  localparam logic [5:0] OP_ST   = 6'd8;
  localparam logic [5:0] OP_BEQZ = 6'd9;
  localparam logic [5:0] OP_J    = 6'd10;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [ADDR_SIZE-1:0] PC_ONE  = 1;
  localparam logic [CNT_SIZE-1:0]  CNT_ONE = 1;

  logic [2:0]           state;
  logic [31:0]          ir;
  logic [DATA_SIZE-1:0] a_q, b_q, s_q, alu_out;
  logic [DATA_SIZE-1:0] regs [NUM_REGS];

  // Instruction fields
  logic [5:0]  op;
  logic [4:0]  r1, r2, r3;
  logic [15:0] imm;
  logic [31:0] imm_sx32, imm_zx32, tgt_zx32;

  assign op       = ir[31:26];
  assign r1       = ir[25:21];
  assign r2       = ir[20:16];
  assign r3       = ir[15:11];
  assign imm      = ir[15:0];
  assign imm_sx32 = {{16{imm[15]}}, imm};
  assign imm_zx32 = {16'h0000, imm};
  assign tgt_zx32 = {6'b000000, ir[25:0]};

  logic [DATA_SIZE-1:0] imm_sext, imm_zext;
  assign imm_sext = {{(DATA_SIZE-16){imm[15]}}, imm};
  assign imm_zext = {{(DATA_SIZE-16){1'b0}}, imm};

  logic op_legal;
  assign op_legal = (op <= OP_J) || (op == OP_HALT);

  // Indices past the implemented file, and R0 when hardwired, read as zero
  function automatic logic [DATA_SIZE-1:0] rf_read(input logic [4:0] idx);
    rf_read = '0;
    if ((int'(idx) < NUM_REGS) && !((ZERO_R0 != 0) && (idx == 5'd0)))
      rf_read = regs[idx[IDX_W-1:0]];
  endfunction

  logic wb_en;
  assign wb_en = (int'(r1) < NUM_REGS) && !((ZERO_R0 != 0) && (r1 == 5'd0));

  // Memory port: request only in FETCH/MEM, and dropped the instant reset asserts
  logic mem_req_i, xfer;
  assign mem_req_i     = reset && ((state == ST_FETCH) || (state == ST_MEM));
  assign xfer          = mem_req_i && mem.mem_ack;
  assign mem.mem_req   = mem_req_i;
  assign mem.mem_we    = mem_req_i && (state == ST_MEM) && (op == OP_ST);
  assign mem.mem_addr  = (state == ST_MEM) ? imm_zx32[ADDR_SIZE-1:0] : pc;
  assign mem.mem_wdata = s_q;

  assign halted = (state == ST_HALT);

  // ALU result for the register/immediate arithmetic ops
  logic [DATA_SIZE-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_ADDI: alu_res = a_q + imm_sext;
      OP_ORI:  alu_res = a_q | imm_zext;
      default: alu_res = '0;
    endcase
  end

  // One retire event per completed instruction, in whichever state finishes it
  logic retire;
  always_comb begin
    retire = 1'b0;
    case (state)
      ST_DECODE: retire = (op == OP_J) || (op == OP_NOP) || (op == OP_HALT) || !op_legal;
      ST_EXEC:   retire = (op == OP_BEQZ);
      ST_MEM:    retire = xfer && (op == OP_ST);
      ST_WB:     retire = 1'b1;
      default:   retire = 1'b0;
    endcase
  end

  // Register file: cleared by reset, written only in WB
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if ((state == ST_WB) && wb_en) begin
      regs[r1[IDX_W-1:0]] <= alu_out;
    end
  end

  // Sequencing FSM with its datapath registers, PC and status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_FETCH;
      pc      <= '0;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      alu_out <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      if (retire) retired <= retired + CNT_ONE;
      case (state)
        ST_FETCH: begin
          if (xfer) begin
            ir    <= mem.mem_rdata[31:0];
            pc    <= pc + PC_ONE;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_q <= rf_read(r2);
          b_q <= rf_read(r3);
          s_q <= rf_read(r1);
          if (!op_legal) begin
            illegal <= 1'b1;
            state   <= ST_FETCH;
          end else if (op == OP_J) begin
            pc    <= tgt_zx32[ADDR_SIZE-1:0];
            state <= ST_FETCH;
          end else if (op == OP_NOP) begin
            state <= ST_FETCH;
          end else if (op == OP_HALT) begin
            state <= ST_HALT;
          end else if ((op == OP_LD) || (op == OP_ST)) begin
            state <= ST_MEM;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op == OP_BEQZ) begin
            // pc already points past the branch, so the offset is relative to pc+1
            if (s_q == '0) pc <= pc + imm_sx32[ADDR_SIZE-1:0];
            state <= ST_FETCH;
          end else begin
            alu_out <= alu_res;
            state   <= ST_WB;
          end
        end
        ST_MEM: begin
          if (xfer) begin
            if (op == OP_LD) begin
              alu_out <= mem.mem_rdata;
              state   <= ST_WB;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_WB:   state <= ST_FETCH;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed bench for mc_datapath_hs: two cores (32-bit/32 regs and 64-bit/8 regs)
// against behavioural wait-state memories; results observed through stores.
// Memory 0 has programmable wait cycles; memory 1 is always zero-wait.
module tb_mc_datapath_hs;

  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- core 0: DATA 32, 32 regs ----------------
  mc_datapath_hs_if #(.DATA_SIZE(32), .ADDR_SIZE(16)) m0 ();
  logic [15:0] pc0;
  logic        halted0, illegal0;
  logic [31:0] retired0;

  mc_datapath_hs #(.DATA_SIZE(32), .ADDR_SIZE(16), .NUM_REGS(32), .ZERO_R0(1), .CNT_SIZE(32)) dut0 (
    .clk(clk), .reset(rst0), .mem(m0), .pc(pc0), .halted(halted0), .illegal(illegal0), .retired(retired0)
  );

  // ---------------- core 1: DATA 64, 8 regs ----------------
  mc_datapath_hs_if #(.DATA_SIZE(64), .ADDR_SIZE(16)) m1 ();
  logic [15:0] pc1;
  logic        halted1, illegal1;
  logic [31:0] retired1;

  mc_datapath_hs #(.DATA_SIZE(64), .ADDR_SIZE(16), .NUM_REGS(8), .ZERO_R0(1), .CNT_SIZE(32)) dut1 (
    .clk(clk), .reset(rst1), .mem(m1), .pc(pc1), .halted(halted1), .illegal(illegal1), .retired(retired1)
  );

  // Memory contents: imem is loaded by the stimulus, wmem holds DUT stores of the current generation
  int          gen = 0;
  int          waits0 = 0;
  int          cnt0 = 0;
  logic [31:0] imem0 [65536];
  logic [31:0] wmem0 [65536];
  int          wgen0 [65536];
  logic [15:0] rd_log0 [$];
  logic [63:0] imem1 [256];
  logic [63:0] wmem1 [256];
  int          wgen1 [256];

  assign m0.mem_ack   = m0.mem_req && (cnt0 >= waits0);
  assign m0.mem_rdata = (wgen0[m0.mem_addr] == gen) ? wmem0[m0.mem_addr] : imem0[m0.mem_addr];
  assign m1.mem_ack   = m1.mem_req;
  assign m1.mem_rdata = (wgen1[m1.mem_addr[7:0]] == gen) ? wmem1[m1.mem_addr[7:0]] : imem1[m1.mem_addr[7:0]];

  // Memory 0: wait-state counter, store commit and read-address log
  always @(posedge clk) begin
    if (m0.mem_req && m0.mem_ack) begin
      cnt0 <= 0;
      if (m0.mem_we) begin
        wmem0[m0.mem_addr] <= m0.mem_wdata;
        wgen0[m0.mem_addr] <= gen;
      end else begin
        rd_log0.push_back(m0.mem_addr);
      end
    end else if (m0.mem_req) begin
      cnt0 <= cnt0 + 1;
    end else begin
      cnt0 <= 0;
    end
  end

  // Memory 1: zero-wait store commit
  always @(posedge clk) begin
    if (m1.mem_req && m1.mem_we) begin
      wmem1[m1.mem_addr[7:0]] <= m1.mem_wdata;
      wgen1[m1.mem_addr[7:0]] <= gen;
    end
  end

  // Stall monitor on port 0: counts unacked request cycles and request-field changes during a stall
  int          stall_cnt = 0;
  int          stab_err = 0;
  logic        hold_vld = 1'b0;
  logic [15:0] h_addr;
  logic        h_we;
  logic [31:0] h_wdata;
  always @(negedge clk) begin
    if (m0.mem_req && !m0.mem_ack) begin
      stall_cnt++;
      if (hold_vld && (m0.mem_addr !== h_addr || m0.mem_we !== h_we || m0.mem_wdata !== h_wdata))
        stab_err++;
      hold_vld = 1'b1;
      h_addr   = m0.mem_addr;
      h_we     = m0.mem_we;
      h_wdata  = m0.mem_wdata;
    end else begin
      if (hold_vld && m0.mem_req &&
          (m0.mem_addr !== h_addr || m0.mem_we !== h_we || m0.mem_wdata !== h_wdata))
        stab_err++;
      hold_vld = 1'b0;
    end
  end

  function automatic logic [31:0] enc_r(input int op, input int r1, input int r2, input int r3);
    return {op[5:0], r1[4:0], r2[4:0], r3[4:0], 11'b0};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int r1, input int r2, input int imm);
    return {op[5:0], r1[4:0], r2[4:0], imm[15:0]};
  endfunction
  function automatic logic [31:0] enc_j(input int op, input int tgt);
    return {op[5:0], tgt[25:0]};
  endfunction

  function automatic logic [31:0] rd0(input int a);
    return (wgen0[a] == gen) ? wmem0[a] : imem0[a];
  endfunction
  function automatic logic [63:0] rd1(input int a);
    return (wgen1[a] == gen) ? wmem1[a] : imem1[a];
  endfunction
  function automatic logic [31:0] log_at(input int i);
    if (i < rd_log0.size()) return {16'h0000, rd_log0[i]};
    return 32'hDEAD_DEAD;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold core 0 in reset and clear its memory to HALT words, starting a fresh store generation
  task automatic begin_prog0();
    @(negedge clk);
    rst0 = 1'b0;
    gen++;
    for (int i = 0; i < 65536; i++) imem0[i] = enc_j(63, 0);
    @(negedge clk);
  endtask

  task automatic release0();
    @(negedge clk);
    rst0 = 1'b1;
  endtask

  task automatic wait_halt0(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && !halted0; i++) @(negedge clk);
    check(tag, {63'b0, halted0}, 64'd1);
  endtask

  int s0, e0, l0;

  initial begin
    // ---- reset state ----
    begin_prog0();
    #1;
    check("rst_pc", pc0, 0);
    check("rst_halted", halted0, 0);
    check("rst_illegal", illegal0, 0);
    check("rst_retired", retired0, 0);
    check("rst_req", m0.mem_req, 0);

    // ---- 1: straight-line ALU program, exact HALT timing ----
    imem0[0] = enc_i(5, 1, 0, 5);
    imem0[1] = enc_i(5, 2, 0, 7);
    imem0[2] = enc_r(1, 3, 1, 2);
    imem0[3] = enc_j(63, 0);
    release0();
    repeat (13) @(negedge clk);
    check("t1_not_halted_13", halted0, 0);
    @(negedge clk);
    check("t1_halted_14", halted0, 1);
    check("t1_retired", retired0, 4);
    check("t1_pc", pc0, 4);
    check("t1_illegal", illegal0, 0);

    // same program, storing r3 to observe it
    begin_prog0();
    imem0[0] = enc_i(5, 1, 0, 5);
    imem0[1] = enc_i(5, 2, 0, 7);
    imem0[2] = enc_r(1, 3, 1, 2);
    imem0[3] = enc_i(8, 3, 0, 'h20);
    imem0[4] = enc_j(63, 0);
    release0();
    wait_halt0("t1b_timeout", 100);
    check("t1b_r3", rd0('h20), 12);
    check("t1b_retired", retired0, 5);

    // ---- 2: two wait cycles per access, LD then ST ----
    begin_prog0();
    waits0 = 2;
    imem0[0]    = enc_i(7, 4, 0, 'h10);
    imem0[1]    = enc_i(8, 4, 0, 'h11);
    imem0[2]    = enc_j(63, 0);
    imem0['h10] = 32'hDEAD_BEEF;
    s0 = stall_cnt;
    e0 = stab_err;
    release0();
    repeat (18) @(negedge clk);
    check("t2_not_halted_18", halted0, 0);
    @(negedge clk);
    check("t2_halted_19", halted0, 1);
    check("t2_store", rd0('h11), 32'hDEAD_BEEF);
    check("t2_stall_cycles", stall_cnt - s0, 10);
    check("t2_stable", stab_err - e0, 0);
    check("t2_retired", retired0, 3);
    waits0 = 0;

    // ---- 3: taken branch, far jump, PC wrap ----
    begin_prog0();
    imem0[0] = enc_i(9, 0, 0, 2);
    imem0[3] = enc_j(10, 'h3FFFFFF);
    l0 = rd_log0.size();
    release0();
    wait_halt0("t3_timeout", 100);
    check("t3_fetch_count", rd_log0.size() - l0, 3);
    check("t3_fetch0", log_at(l0), 0);
    check("t3_fetch1", log_at(l0 + 1), 3);
    check("t3_fetch2", log_at(l0 + 2), 'hFFFF);
    check("t3_pc_wrap", pc0, 0);
    check("t3_retired", retired0, 3);

    // ---- 4a: hardwired R0 ----
    begin_prog0();
    imem0[0]    = enc_i(5, 0, 0, 9);
    imem0[1]    = enc_r(1, 5, 0, 0);
    imem0[2]    = enc_i(8, 5, 0, 'h30);
    imem0[3]    = enc_i(8, 0, 0, 'h31);
    imem0[4]    = enc_j(63, 0);
    imem0['h30] = 32'hFFFF_FFFF;
    imem0['h31] = 32'hFFFF_FFFF;
    release0();
    wait_halt0("t4a_timeout", 100);
    check("t4a_r5", rd0('h30), 0);
    check("t4a_r0", rd0('h31), 0);

    // ---- 4b: remaining ALU ops and an untaken branch ----
    begin_prog0();
    imem0[0]  = enc_i(5, 1, 0, 'hFFFD);
    imem0[1]  = enc_i(6, 2, 0, 'h00F0);
    imem0[2]  = enc_r(2, 3, 2, 1);
    imem0[3]  = enc_r(3, 4, 1, 2);
    imem0[4]  = enc_r(4, 6, 1, 2);
    imem0[5]  = enc_i(6, 7, 2, 'h8001);
    imem0[6]  = enc_i(9, 1, 0, 5);
    imem0[7]  = enc_i(8, 3, 0, 'h40);
    imem0[8]  = enc_i(8, 4, 0, 'h41);
    imem0[9]  = enc_i(8, 6, 0, 'h42);
    imem0[10] = enc_i(8, 7, 0, 'h43);
    imem0[11] = enc_j(63, 0);
    release0();
    wait_halt0("t4b_timeout", 200);
    check("t4b_sub", rd0('h40), 32'h0000_00F3);
    check("t4b_and", rd0('h41), 32'h0000_00F0);
    check("t4b_or", rd0('h42), 32'hFFFF_FFFD);
    check("t4b_ori", rd0('h43), 32'h0000_80F1);
    check("t4b_retired", retired0, 12);
    check("t4b_pc", pc0, 12);

    // ---- 5: undefined opcode ----
    begin_prog0();
    imem0[0] = enc_j(42, 0);
    imem0[1] = enc_i(5, 1, 0, 1);
    imem0[2] = enc_i(8, 1, 0, 'h60);
    imem0[3] = enc_j(63, 0);
    release0();
    repeat (2) @(negedge clk);
    check("t5_illegal_set", illegal0, 1);
    check("t5_pc", pc0, 1);
    check("t5_retired_1", retired0, 1);
    wait_halt0("t5_timeout", 100);
    check("t5_illegal_sticky", illegal0, 1);
    check("t5_retired_4", retired0, 4);
    check("t5_store", rd0('h60), 1);

    // ---- 6: reset in the middle of a stalled store ----
    begin_prog0();
    waits0 = 4;
    imem0[0]    = enc_i(5, 1, 0, 'h55);
    imem0[1]    = enc_i(8, 1, 0, 'h50);
    imem0[2]    = enc_j(63, 0);
    imem0['h50] = 32'h0;
    release0();
    for (int i = 0; i < 100 && !(m0.mem_req && m0.mem_we); i++) @(negedge clk);
    check("t6_store_seen", m0.mem_we, 1);
    check("t6_retired_pre", retired0, 1);
    @(negedge clk);
    rst0 = 1'b0;
    #1;
    check("t6_req_drop", m0.mem_req, 0);
    check("t6_pc", pc0, 0);
    check("t6_retired", retired0, 0);
    check("t6_halted", halted0, 0);
    repeat (6) @(negedge clk);
    check("t6_no_write", rd0('h50), 0);
    waits0 = 0;
    rst0 = 1'b1;
    #1;
    check("t6_first_req", m0.mem_req, 1);
    check("t6_first_addr", m0.mem_addr, 0);
    check("t6_first_we", m0.mem_we, 0);
    wait_halt0("t6_timeout", 100);
    check("t6_rerun_store", rd0('h50), 32'h55);

    // ---- 4c: 64-bit datapath with 8 registers ----
    @(negedge clk);
    gen++;
    for (int i = 0; i < 256; i++) imem1[i] = {32'h0, enc_j(63, 0)};
    imem1[0]    = {32'h0, enc_i(5, 1, 0, 'hFFFF)};
    imem1[1]    = {32'h0, enc_i(5, 9, 0, 7)};
    imem1[2]    = {32'h0, enc_r(1, 2, 9, 1)};
    imem1[3]    = {32'h0, enc_i(8, 1, 0, 'h10)};
    imem1[4]    = {32'h0, enc_i(8, 2, 0, 'h11)};
    imem1[5]    = {32'h0, enc_i(8, 9, 0, 'h12)};
    imem1[6]    = {32'h0, enc_j(63, 0)};
    imem1['h12] = 64'h1234;
    #1;
    check("t4c_rst_retired", retired1, 0);
    @(negedge clk);
    rst1 = 1'b1;
    for (int i = 0; i < 200 && !halted1; i++) @(negedge clk);
    check("t4c_timeout", halted1, 1);
    check("t4c_r1_all_ones", rd1('h10), 64'hFFFF_FFFF_FFFF_FFFF);
    check("t4c_r9_write_dropped", rd1('h11), 64'hFFFF_FFFF_FFFF_FFFF);
    check("t4c_r9_reads_zero", rd1('h12), 64'h0);
    check("t4c_retired", retired1, 7);
    check("t4c_illegal", illegal1, 0);
    check("t4c_pc", pc1, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
